// File: rtl/nco_sweep_pkg.sv
// Shared state encoding, default widths and count helpers for the NCO sweep sequencer.
// Optional build macro: NCO_SWEEP_LOOP_EN (see nco_sweep_ctrl).
package nco_sweep_pkg;

    localparam int DEF_PHI_W      = 20;
    localparam int DEF_SMP_W      = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // A configured count of zero behaves as a count of one.
    function automatic logic [DEF_CNT_W-1:0] norm_count(input logic [DEF_CNT_W-1:0] cnt);
        logic [DEF_CNT_W-1:0] res;
        if (cnt == '0) begin
            res = DEF_CNT_W'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/nco_sweep_timer.sv
// Loadable down-counter used to time the NCO settle window.
// zero_o flags the decrement that empties the counter, so a load of N expires after N decrements.
module nco_sweep_timer
    import nco_sweep_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = dec_i && (cnt_q <= W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the fsin NCO: steps phi_inc, discards settle samples, forwards dwell samples.
// Define NCO_SWEEP_LOOP_EN to repeat the sweep continuously until abort instead of finishing with done.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int PHI_W      = DEF_PHI_W,
    parameter int SMP_W      = DEF_SMP_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PHI_W-1:0] cfg_start_inc,
    input  logic [PHI_W-1:0] cfg_step_inc,
    input  logic [CNT_W-1:0] cfg_num_steps,
    input  logic [CNT_W-1:0] cfg_dwell,
    output logic [PHI_W-1:0] phi_inc_o,
    output logic             nco_clken,
    input  logic             nco_valid_i,
    input  logic [SMP_W-1:0] nco_smp_i,
    output logic [SMP_W-1:0] smp_o,
    output logic             smp_valid,
    output logic [CNT_W-1:0] smp_idx,
    output logic             busy,
    output logic             done
);

`ifdef NCO_SWEEP_LOOP_EN
    localparam sweep_state_e LAST_PT_NEXT = ST_SETTLE;
`else
    localparam sweep_state_e LAST_PT_NEXT = ST_DONE;
`endif

    sweep_state_e state_q, state_d;

    logic [PHI_W-1:0] phi_q, phi_d;
    logic [CNT_W-1:0] pt_idx_q, pt_idx_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic             smp_valid_q, smp_valid_d;
    logic [CNT_W-1:0] smp_idx_q, smp_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clken_q, clken_d;
    logic [PHI_W-1:0] sh_step_q, sh_step_d;
    logic [CNT_W-1:0] sh_steps_q, sh_steps_d;
    logic [CNT_W-1:0] sh_dwell_q, sh_dwell_d;
`ifdef NCO_SWEEP_LOOP_EN
    logic [PHI_W-1:0] sh_start_q, sh_start_d;
`endif

    logic start_ok_s;
    logic take_s;
    logic last_smp_s;
    logic last_pt_s;
    logic timer_load_s;
    logic timer_dec_s;
    logic settle_zero_s;

    assign start_ok_s  = (state_q == ST_IDLE) && start && !abort;
    assign take_s      = (state_q == ST_DWELL) && nco_valid_i && !abort;
    assign last_smp_s  = (dwell_cnt_q == (sh_dwell_q - CNT_W'(1)));
    assign last_pt_s   = (pt_idx_q == (sh_steps_q - CNT_W'(1)));
    assign timer_dec_s = (state_q == ST_SETTLE);

    nco_sweep_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load_s),
        .load_val_i (CNT_W'(SETTLE_CYC)),
        .dec_i      (timer_dec_s),
        .zero_o     (settle_zero_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_SETTLE;
                else            state_d = ST_IDLE;
            end
            ST_SETTLE: begin
                if (abort)              state_d = ST_IDLE;
                else if (settle_zero_s) state_d = ST_DWELL;
                else                    state_d = ST_SETTLE;
            end
            ST_DWELL: begin
                if (abort)                                  state_d = ST_IDLE;
                else if (take_s && last_smp_s && last_pt_s) state_d = LAST_PT_NEXT;
                else if (take_s && last_smp_s)              state_d = ST_SETTLE;
                else                                        state_d = ST_DWELL;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state register.
    always_comb begin
        phi_d        = phi_q;
        pt_idx_d     = pt_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        smp_d        = smp_q;
        smp_valid_d  = 1'b0;
        smp_idx_d    = smp_idx_q;
        sh_step_d    = sh_step_q;
        sh_steps_d   = sh_steps_q;
        sh_dwell_d   = sh_dwell_q;
`ifdef NCO_SWEEP_LOOP_EN
        sh_start_d   = sh_start_q;
`endif
        timer_load_s = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        clken_d      = (state_d == ST_SETTLE) || (state_d == ST_DWELL);

        if (start_ok_s) begin
            sh_step_d    = cfg_step_inc;
            sh_steps_d   = norm_count(cfg_num_steps);
            sh_dwell_d   = norm_count(cfg_dwell);
`ifdef NCO_SWEEP_LOOP_EN
            sh_start_d   = cfg_start_inc;
`endif
            phi_d        = cfg_start_inc;
            pt_idx_d     = '0;
            smp_idx_d    = '0;
            timer_load_s = 1'b1;
        end else if ((state_q == ST_SETTLE) && (state_d == ST_DWELL)) begin
            dwell_cnt_d = '0;
        end else if (take_s) begin
            // The forwarded sample keeps the index of the point it was captured in.
            smp_d       = nco_smp_i;
            smp_valid_d = 1'b1;
            smp_idx_d   = pt_idx_q;
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
            if (last_smp_s && !last_pt_s) begin
                phi_d        = phi_q + sh_step_q;
                pt_idx_d     = pt_idx_q + CNT_W'(1);
                timer_load_s = 1'b1;
            end else if (last_smp_s) begin
`ifdef NCO_SWEEP_LOOP_EN
                phi_d        = sh_start_q;
                pt_idx_d     = '0;
                timer_load_s = 1'b1;
`else
                pt_idx_d     = pt_idx_q;
`endif
            end else begin
                pt_idx_d = pt_idx_q;
            end
        end else begin
            dwell_cnt_d = dwell_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_q       <= '0;
            pt_idx_q    <= '0;
            dwell_cnt_q <= '0;
            smp_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clken_q     <= 1'b0;
            sh_step_q   <= '0;
            sh_steps_q  <= '0;
            sh_dwell_q  <= '0;
`ifdef NCO_SWEEP_LOOP_EN
            sh_start_q  <= '0;
`endif
        end else begin
            phi_q       <= phi_d;
            pt_idx_q    <= pt_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            smp_q       <= smp_d;
            smp_valid_q <= smp_valid_d;
            smp_idx_q   <= smp_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            clken_q     <= clken_d;
            sh_step_q   <= sh_step_d;
            sh_steps_q  <= sh_steps_d;
            sh_dwell_q  <= sh_dwell_d;
`ifdef NCO_SWEEP_LOOP_EN
            sh_start_q  <= sh_start_d;
`endif
        end
    end

    assign phi_inc_o = phi_q;
    assign nco_clken = clken_q;
    assign smp_o     = smp_q;
    assign smp_valid = smp_valid_q;
    assign smp_idx   = smp_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
